delay_mem_sched: RTL and testbench

//  Per-sample-frame scheduler for the single read port of the shared delay-line sample RAM.

---
 rtl/delay_mem_sched.sv | 192 +++++++++++++++++++
 tb/tb_delay_mem_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/delay_mem_sched.sv
// ---------------------------------------------------------------------------
// delay_mem_sched
//   Per-frame read scheduler for the single read port of the shared
//   delay-line sample RAM. Once per sample frame it latches the main, chorus
//   and reverb read requests and addresses. It issues one RAM read per cycle
//   in fixed priority (main > chor > rev), skipping absent requesters. It
//   returns the read data with a one-hot owner pulse, and pulses frame_done
//   once every read of the frame has come back.
//
//   Optional feature: define OVERRUN_CNT_EN to count frame_start strobes
//   that arrive while a frame is still in progress. The count saturates at
//   255. Without the macro, overrun_cnt is tied to zero.
//
// Parameters
//   AW      sample RAM address width
//   DW      sample data width
//   RD_LAT  RAM read latency, mem_re cycle to mem_rdata valid (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   frame_start  one-cycle strobe marking a new sample frame
//   main_req/main_addr, chor_req/chor_addr, rev_req/rev_addr
//                per-path read request and address, sampled at frame_start
//   mem_re, mem_addr   RAM read enable / address (address holds when idle)
//   mem_rdata          RAM read data, valid RD_LAT cycles after mem_re
//   rd_data            registered return data, held between pulses
//   main_valid, chor_valid, rev_valid   one-cycle owner pulse for rd_data
//   busy               frame in progress (state != IDLE)
//   frame_done         one-cycle pulse, all reads of the frame returned
//   overrun_cnt        frame_start strobes ignored while busy
// ---------------------------------------------------------------------------
module delay_mem_sched #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          main_req,
  input  logic [AW-1:0] main_addr,
  input  logic          chor_req,
  input  logic [AW-1:0] chor_addr,
  input  logic          rev_req,
  input  logic [AW-1:0] rev_addr,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rd_data,
  output logic          main_valid,
  output logic          chor_valid,
  output logic          rev_valid,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    overrun_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_MAIN = 2'd1;
  localparam logic [1:0] TAG_CHOR = 2'd2;
  localparam logic [1:0] TAG_REV  = 2'd3;

  state_t        state, next_state;
  logic [2:0]    pend, pend_next;        // {main, chor, rev} still to issue
  logic [AW-1:0] main_lat, chor_lat, rev_lat;
  logic [AW-1:0] addr_hold, sel_addr;
  logic [1:0]    issue_tag;
  logic [1:0]    tag_pipe [RD_LAT];      // owner of each read in flight
  logic          pipe_busy;
  logic [1:0]    ret_tag;

  // Issue selection: the highest-priority pending requester goes this cycle.
  // Its bit is cleared, so the next cycle moves to the next requester and
  // absent requesters leave no gap.
  always_comb begin
    issue_tag = TAG_NONE;
    sel_addr  = addr_hold;
    pend_next = pend;
    if (state == ISSUE) begin
      if (pend[2]) begin
        issue_tag = TAG_MAIN;
        sel_addr  = main_lat;
        pend_next = {1'b0, pend[1:0]};
      end else if (pend[1]) begin
        issue_tag = TAG_CHOR;
        sel_addr  = chor_lat;
        pend_next = {2'b00, pend[0]};
      end else if (pend[0]) begin
        issue_tag = TAG_REV;
        sel_addr  = rev_lat;
        pend_next = 3'b000;
      end
    end
  end

  assign mem_re   = (issue_tag != TAG_NONE);
  assign mem_addr = sel_addr;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_busy = pipe_busy | (tag_pipe[i] != TAG_NONE);
    end
  end

  // The tag at the end of the pipe marks the cycle in which mem_rdata is valid.
  assign ret_tag = tag_pipe[RD_LAT-1];

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (frame_start) begin
          next_state = (main_req || chor_req || rev_req) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (pend_next == 3'b000) next_state = DRAIN;
      end
      // The pipe empties in the same cycle the last owner pulse is shown,
      // so frame_done follows that pulse directly.
      DRAIN: begin
        if (!pipe_busy) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pend      <= 3'b000;
      main_lat  <= '0;
      chor_lat  <= '0;
      rev_lat   <= '0;
      addr_hold <= '0;
    end else begin
      state     <= next_state;
      addr_hold <= sel_addr;
      if (state == IDLE && frame_start) begin
        pend     <= {main_req, chor_req, rev_req};
        main_lat <= main_addr;
        chor_lat <= chor_addr;
        rev_lat  <= rev_addr;
      end else begin
        pend <= pend_next;
      end
    end
  end

  // Return path: the tag pipe stages _p0.._p(RD_LAT-1), then the output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
      rd_data    <= '0;
      main_valid <= 1'b0;
      chor_valid <= 1'b0;
      rev_valid  <= 1'b0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (ret_tag != TAG_NONE) rd_data <= mem_rdata;
      main_valid <= (ret_tag == TAG_MAIN);
      chor_valid <= (ret_tag == TAG_CHOR);
      rev_valid  <= (ret_tag == TAG_REV);
    end
  end

`ifdef OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 8'd0;
    end else if (frame_start && (state != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_delay_mem_sched.sv
module tb_delay_mem_sched;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          main_req, chor_req, rev_req;
  logic [AW-1:0] main_addr, chor_addr, rev_addr;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rd_data;
  logic          main_valid, chor_valid, rev_valid;
  logic          busy, frame_done;
  logic [7:0]    overrun_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  delay_mem_sched #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .main_req(main_req), .main_addr(main_addr),
    .chor_req(chor_req), .chor_addr(chor_addr),
    .rev_req(rev_req), .rev_addr(rev_addr),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rd_data(rd_data), .main_valid(main_valid), .chor_valid(chor_valid),
    .rev_valid(rev_valid), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  // RAM model with two-cycle read latency; contents are a fixed address function.
  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return (a == 12'h155) ? 16'hBEEF : {4'h5, a};
  endfunction

  logic [DW-1:0] ram_d1 = '0;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    ram_d1    <= mem_re ? ram_val(mem_addr) : '0;
    mem_rdata <= ram_d1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          fs;
    logic [2:0]    req;      // {main, chor, rev}
    logic [AW-1:0] ma, ca, ra;
    logic          e_re;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_vld;    // {main, chor, rev}
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fs, input logic [2:0] req,
                              input logic [AW-1:0] ma, input logic [AW-1:0] ca,
                              input logic [AW-1:0] ra, input logic e_re,
                              input logic [AW-1:0] e_addr, input logic [2:0] e_vld,
                              input logic [DW-1:0] e_data, input logic e_busy,
                              input logic e_done);
    vec_t v;
    v.fs = fs; v.req = req; v.ma = ma; v.ca = ca; v.ra = ra;
    v.e_re = e_re; v.e_addr = e_addr; v.e_vld = e_vld; v.e_data = e_data;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic drive(input logic fs, input logic [2:0] req, input logic [AW-1:0] ma,
                       input logic [AW-1:0] ca, input logic [AW-1:0] ra);
    frame_start = fs;
    {main_req, chor_req, rev_req} = req;
    main_addr = ma; chor_addr = ca; rev_addr = ra;
  endtask

  logic [7:0] exp_ovr;

  initial begin
`ifdef OVERRUN_CNT_EN
    exp_ovr = 8'd1;
`else
    exp_ovr = 8'd0;
`endif
    // Each row: inputs applied during that cycle, outputs expected during that cycle.
    // Frame A: all three requests; inputs change at cycle 1; extra frame_start at cycle 3.
    vecs.push_back(mk(1, 3'b111, 12'h010, 12'h020, 12'h030, 0, 12'h000, 3'b000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h3FF, 12'h3EE, 12'h3DD, 1, 12'h010, 3'b000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 3'b101, 12'h3FF, 12'h3EE, 12'h3DD, 1, 12'h020, 3'b000, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 3'b111, 12'h3FF, 12'h3EE, 12'h3DD, 1, 12'h030, 3'b000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h030, 3'b100, 16'h5010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h030, 3'b010, 16'h5020, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h030, 3'b001, 16'h5030, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h030, 3'b000, 16'h5030, 1, 1));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h030, 3'b000, 16'h5030, 0, 0));
    // Frame B: chorus only.
    vecs.push_back(mk(1, 3'b010, 12'h111, 12'h155, 12'h222, 0, 12'h030, 3'b000, 16'h5030, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 1, 12'h155, 3'b000, 16'h5030, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'h5030, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'h5030, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b010, 16'hBEEF, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'hBEEF, 1, 1));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'hBEEF, 0, 0));
    // Frame C: no requests.
    vecs.push_back(mk(1, 3'b000, 12'h0AA, 12'h0BB, 12'h0CC, 0, 12'h155, 3'b000, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'hBEEF, 1, 1));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h155, 3'b000, 16'hBEEF, 0, 0));
    // Frame D: main and reverb, chorus skipped without a bubble.
    vecs.push_back(mk(1, 3'b101, 12'h0AA, 12'h0BB, 12'h0CC, 0, 12'h155, 3'b000, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 1, 12'h0AA, 3'b000, 16'hBEEF, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 1, 12'h0CC, 3'b000, 16'hBEEF, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h0CC, 3'b000, 16'hBEEF, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h0CC, 3'b100, 16'h50AA, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h0CC, 3'b001, 16'h50CC, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h0CC, 3'b000, 16'h50CC, 1, 1));
    vecs.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 0, 12'h0CC, 3'b000, 16'h50CC, 0, 0));

    drive(0, 3'b000, '0, '0, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset mem_re", {31'd0, mem_re}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rd_data", {16'd0, rd_data}, 32'd0);
    chk("reset valids", {29'd0, main_valid, chor_valid, rev_valid}, 32'd0);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset overrun", {24'd0, overrun_cnt}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].fs, vecs[i].req, vecs[i].ma, vecs[i].ca, vecs[i].ra);
      #1;
      chk($sformatf("row%0d mem_re", i), {31'd0, mem_re}, {31'd0, vecs[i].e_re});
      chk($sformatf("row%0d mem_addr", i), {20'd0, mem_addr}, {20'd0, vecs[i].e_addr});
      chk($sformatf("row%0d valids", i), {29'd0, main_valid, chor_valid, rev_valid},
          {29'd0, vecs[i].e_vld});
      chk($sformatf("row%0d rd_data", i), {16'd0, rd_data}, {16'd0, vecs[i].e_data});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("row%0d frame_done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_done});
    end
    chk("overrun count", {24'd0, overrun_cnt}, {24'd0, exp_ovr});

    // Reset in the middle of a three-request frame.
    @(negedge clk); drive(1, 3'b111, 12'h010, 12'h020, 12'h030);
    @(negedge clk); drive(0, 3'b000, '0, '0, '0);
    #1 chk("midrst c1 mem_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    #1 chk("midrst c2 addr", {20'd0, mem_addr}, 32'h020);
    reset = 1'b0;
    #1;
    chk("midrst mem_re drop", {31'd0, mem_re}, 32'd0);
    chk("midrst busy drop", {31'd0, busy}, 32'd0);
    chk("midrst valids drop", {29'd0, main_valid, chor_valid, rev_valid}, 32'd0);
    chk("midrst overrun clr", {24'd0, overrun_cnt}, 32'd0);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("postrst c%0d quiet", c),
          {27'd0, mem_re, busy, frame_done, (main_valid | chor_valid | rev_valid), 1'b0},
          32'd0);
    end

    // Recovery: a clean chorus-only frame after reset.
    @(negedge clk); drive(1, 3'b010, 12'h000, 12'h155, 12'h000);
    @(negedge clk); drive(0, 3'b000, '0, '0, '0);
    #1 chk("recover issue", {19'd0, mem_re, mem_addr}, {19'd0, 1'b1, 12'h155});
    repeat (3) @(negedge clk);
    #1;
    chk("recover chor_valid", {29'd0, main_valid, chor_valid, rev_valid}, 32'd2);
    chk("recover rd_data", {16'd0, rd_data}, 32'hBEEF);
    @(negedge clk); #1;
    chk("recover frame_done", {31'd0, frame_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
